// File: rtl/fetch_unit.sv
// Instruction fetch: PC register driving a combinational imem, with a valid/ready output register to decode.
// Fetch latency is one cycle; a stalled output (out_valid & !out_ready) freezes the PC, and redirect overrides the stall.
module fetch_unit #(
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_STEP  = 1,
    parameter int unsigned        CNT_W    = 8,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  fetch_count
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;
    logic              slot;

    always_comb begin
        slot          = !out_valid_q || out_ready;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        cycle_count_d = cycle_count_q + CNT_W'(1);
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            // The word currently on imem_rdata is on the wrong path and is dropped.
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
            out_instr_d = NOP_WORD;
            out_pc_d    = '0;
        end else if (!halt && slot) begin
            pc_d          = pc_q + ADDR_W'(PC_STEP);
            out_valid_d   = 1'b1;
            out_instr_d   = imem_rdata;
            out_pc_d      = pc_q;
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end else if (slot) begin
            out_valid_d = 1'b0;
            out_instr_d = NOP_WORD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_instr_q   <= NOP_WORD;
            out_pc_q      <= '0;
            cycle_count_q <= '0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            cycle_count_q <= cycle_count_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign cycle_count = cycle_count_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of accepted PCs for streaming, vector table for redirect/halt/stall/wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic [7:0]  cycle_count;
    logic [7:0]  fetch_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] edges = 8'd0;
    logic [7:0] sb_q[$];
    logic       sb_en = 1'b0;

    typedef struct {
        logic       h;
        logic       rdy;
        logic       rv;
        logic [7:0] rpc;
        logic       ev;
        logic [7:0] epc;
        logic [7:0] eaddr;
    } vec_t;
    vec_t vecs[$];

    fetch_unit #(
        .ADDR_W(8), .DATA_W(32), .RESET_PC(8'h10), .PC_STEP(1), .CNT_W(8), .NOP_WORD(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .cycle_count(cycle_count), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_rdata = 32'hA000_0000 + {24'h0, imem_addr};

    always @(posedge clk) begin
        if (rst) edges <= 8'd0;
        else     edges <= edges + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every accepted word must be the next expected PC, in order.
    always @(negedge clk) begin
        if (sb_en && !rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_word", {24'h0, out_pc}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] p;
                p = sb_q.pop_front();
                chk("sb_pc", {24'h0, out_pc}, {24'h0, p});
                chk("sb_instr", out_instr, 32'hA000_0000 + {24'h0, p});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic h, input logic rdy, input logic rv, input logic [7:0] rpc,
                       input logic ev, input logic [7:0] epc, input logic [7:0] eaddr);
        vec_t v;
        v.h = h; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr;
        vecs.push_back(v);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_addr"}, {24'h0, imem_addr}, 32'h10);
        chk({tag, "_instr"}, out_instr, 32'h0);
        chk({tag, "_pc"}, {24'h0, out_pc}, 32'h0);
        chk({tag, "_cycles"}, {24'h0, cycle_count}, 32'h0);
        chk({tag, "_fetches"}, {24'h0, fetch_count}, 32'h0);
    endtask

    initial begin
        //   halt rdy rv rpc     ev  epc    eaddr
        add(0, 1, 1, 8'h04, 0, 8'h00, 8'h04);  // redirect from stream
        add(0, 1, 0, 8'h00, 1, 8'h04, 8'h05);
        add(0, 1, 0, 8'h00, 1, 8'h05, 8'h06);
        add(0, 1, 1, 8'h40, 0, 8'h00, 8'h40);  // redirect while out_pc=0x05
        add(0, 1, 0, 8'h00, 1, 8'h40, 8'h41);
        add(0, 1, 0, 8'h00, 1, 8'h41, 8'h42);
        add(0, 0, 0, 8'h00, 1, 8'h41, 8'h42);  // stall
        add(0, 0, 1, 8'h80, 0, 8'h00, 8'h80);  // redirect kills stalled word
        add(0, 0, 0, 8'h00, 1, 8'h80, 8'h81);
        add(0, 0, 0, 8'h00, 1, 8'h80, 8'h81);
        add(0, 1, 0, 8'h00, 1, 8'h81, 8'h82);
        add(0, 1, 1, 8'h20, 0, 8'h00, 8'h20);  // back-to-back redirects
        add(0, 1, 1, 8'h30, 0, 8'h00, 8'h30);
        add(0, 1, 0, 8'h00, 1, 8'h30, 8'h31);
        add(0, 1, 1, 8'hFE, 0, 8'h00, 8'hFE);  // PC wrap
        add(0, 1, 0, 8'h00, 1, 8'hFE, 8'hFF);
        add(0, 1, 0, 8'h00, 1, 8'hFF, 8'h00);
        add(0, 1, 0, 8'h00, 1, 8'h00, 8'h01);
        add(1, 1, 0, 8'h00, 0, 8'h00, 8'h01);  // halt drains, pc held
        add(1, 1, 0, 8'h00, 0, 8'h00, 8'h01);
        add(0, 1, 0, 8'h00, 1, 8'h01, 8'h02);
        add(1, 0, 0, 8'h00, 1, 8'h01, 8'h02);  // halt while stalled holds word
        add(1, 1, 0, 8'h00, 0, 8'h00, 8'h02);
        add(0, 1, 0, 8'h00, 1, 8'h02, 8'h03);
        add(1, 1, 1, 8'h50, 0, 8'h00, 8'h50);  // redirect overrides halt
        add(1, 1, 0, 8'h00, 0, 8'h00, 8'h50);
        add(0, 1, 0, 8'h00, 1, 8'h50, 8'h51);

        rst = 1'b1; halt = 1'b0; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 8'h00;
        #1;
        chk_reset_state("reset");
        tick(); tick();
        chk("reset_hold_cycles", {24'h0, cycle_count}, 32'h0);

        // Stream from RESET_PC through the scoreboard.
        rst = 1'b0;
        sb_q.push_back(8'h10); sb_q.push_back(8'h11);
        sb_en = 1'b1;
        tick();
        chk("first_fetch_valid", {31'h0, out_valid}, 32'h1);
        chk("first_fetch_count", {24'h0, fetch_count}, 32'h1);
        tick(); tick();
        chk("stream_fetch_count", {24'h0, fetch_count}, 32'h3);
        chk("stream_pc", {24'h0, out_pc}, 32'h12);

        // Backpressure on 0x12 for three cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_pc", {24'h0, out_pc}, 32'h12);
            chk("bp_instr", out_instr, 32'hA000_0012);
            chk("bp_addr", {24'h0, imem_addr}, 32'h13);
        end
        sb_q.push_back(8'h12); sb_q.push_back(8'h13);
        out_ready = 1'b1;
        tick(); tick();
        sb_en = 1'b0;
        chk("bp_after_pc", {24'h0, out_pc}, 32'h14);
        chk("sb_drained", sb_q.size(), 32'h0);
        chk("bp_fetch_count", {24'h0, fetch_count}, 32'h5);

        foreach (vecs[i]) begin
            halt = vecs[i].h;
            out_ready = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc;
            tick();
            chk($sformatf("vec%0d_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].ev});
            chk($sformatf("vec%0d_addr", i), {24'h0, imem_addr}, {24'h0, vecs[i].eaddr});
            chk($sformatf("vec%0d_cycles", i), {24'h0, cycle_count}, {24'h0, edges});
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_pc", i), {24'h0, out_pc}, {24'h0, vecs[i].epc});
                chk($sformatf("vec%0d_instr", i), out_instr, 32'hA000_0000 + {24'h0, vecs[i].epc});
            end else begin
                chk($sformatf("vec%0d_nop", i), out_instr, 32'h0);
            end
        end
        halt = 1'b0; redirect_valid = 1'b0;
        chk("table_fetch_count", {24'h0, fetch_count}, 32'd18);

        // Async reset while a word is stalled.
        out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk_reset_state("async_rst");
        tick();
        rst = 1'b0; out_ready = 1'b1;
        tick();
        chk("post_rst_pc", {24'h0, out_pc}, 32'h10);
        chk("post_rst_valid", {31'h0, out_valid}, 32'h1);
        chk("post_rst_fetches", {24'h0, fetch_count}, 32'h1);
        chk("post_rst_cycles", {24'h0, cycle_count}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage. Owns the program counter, drives a combinational instruction memory, and registers each fetched word together with its PC into a valid/ready output register that feeds decode. It is the successor to the fixed 8-bit/32-bit fetch stage and adds:
- reset
- downstream backpressure
- branch/jump redirect with wrong-path kill
- halt
- fetch and cycle counters

## Interface
Parameters:
- ADDR_W, 8, PC and instruction-memory address width (word address).
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, PC increment per accepted fetch.
- CNT_W, 8, width of cycle_count and fetch_count.
- NOP_WORD, 0, value driven on out_instr when the register holds no valid instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- imem_addr  out  ADDR_W  current PC; combinational from the PC register.
- imem_rdata  in  DATA_W  instruction at imem_addr; combinational read, valid in the same cycle.
- redirect_valid  in  1  load a new PC and kill in-flight wrong-path work.
- redirect_pc  in  ADDR_W  target PC; sampled only when redirect_valid=1.
- halt  in  1  level; while high, no new fetch is accepted.
- out_valid  out  1  out_instr and out_pc hold a live instruction.
- out_ready  in  1  decode accepts the word this cycle.
- out_instr  out  DATA_W  registered instruction.
- out_pc  out  ADDR_W  PC of out_instr.
- cycle_count  out  CNT_W  free-running cycle counter.
- fetch_count  out  CNT_W  number of instructions loaded into the output register.

## Operation
- State consists of:
  - pc register
  - output register {out_valid, out_instr, out_pc}
  - two counters
- Handshake on an edge: out_valid & out_ready. This completes the transfer.
- Free slot: slot = !out_valid | out_ready.
- Priority on each rising edge, highest first:
  1. **Redirect:** if redirect_valid=1:
     - pc <= redirect_pc
     - out_valid <= 0, out_instr <= NOP_WORD, out_pc <= 0
     - The word currently on imem_rdata is discarded.
     - A handshake on the same edge still counts as completed.
     - Overrides halt and backpressure.
  2. **Fetch:** else if halt=0 and slot=1:
     - out_instr <= imem_rdata, out_pc <= pc, out_valid <= 1
     - pc <= pc + PC_STEP, modulo 2^ADDR_W (wraps silently)
     - fetch_count += 1
  3. **Drain:** else if slot=1 (halted): out_valid <= 0, out_instr <= NOP_WORD. pc is held.
  4. **Stall:** else (out_valid=1, out_ready=0): all state is held and out_* is stable.
- cycle_count increments by 1 every edge not in reset and wraps at 2^CNT_W.
- fetch_count wraps at 2^CNT_W.
- out_* must never change while out_valid=1 and out_ready=0, except on redirect.
- redirect_pc is not alignment-checked; any value is legal.

## Timing
- **Reset (async, immediate):**
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - out_valid = 0, out_instr = NOP_WORD, out_pc = 0.
  - cycle_count = 0, fetch_count = 0.
- **Reset mid-operation:** the above state is restored immediately, regardless of pending handshake or redirect. The first fetch happens on the first edge after rst deasserts (if halt=0).
- **Fetch latency:** the PC present in cycle N appears on out_pc/out_instr in cycle N+1.
- **Throughput:** 1 instruction/cycle with out_ready held high.
- **Redirect asserted in cycle N:**
  - Cycle N+1: imem_addr = redirect_pc, out_valid = 0.
  - Cycle N+2: out_pc = redirect_pc.
  - Exactly one bubble.
- **Back-to-back redirects:** the last one wins. out_valid stays 0 until one cycle after the final redirect.
- **Halt:** takes effect on the same edge. Deassertion resumes fetch at the held pc on the next edge.
- **Backpressure:** out_ready=0 with out_valid=1 freezes pc, so no instruction is skipped or duplicated.

## Test plan
- **Reset and stream:**
  - Stimulus: RESET_PC=0x10, imem[a]=0xA000_0000+a, out_ready=1, release rst.
  - Required: out_pc sequence 0x10, 0x11, 0x12… with matching out_instr; fetch_count=3 after 3 edges.
- **Backpressure:**
  - Stimulus: drop out_ready for 3 cycles while out_pc=0x12.
  - Required: out_pc/out_instr held at 0x12; then 0x13 follows with no gap or duplicate.
- **Redirect:**
  - Stimulus: redirect_valid for 1 cycle with redirect_pc=0x40, while out_pc=0x05.
  - Required: next cycle out_valid=0 and imem_addr=0x40; cycle after, out_pc=0x40 with instr 0xA000_0040.
- **Redirect during stall:**
  - Stimulus: out_ready=0, out_valid=1, redirect_pc=0x80.
  - Required: stalled word killed (out_valid=0); then 0x80 delivered.
- **Wrap and halt:**
  - Stimulus: ADDR_W=8, redirect to 0xFE, stream.
  - Required: out_pc 0xFE, 0xFF, 0x00.
  - Stimulus: halt for 2 cycles.
  - Required: out_valid drops after consumption; pc held; resume at the held pc.
- **Async reset mid-stall:**
  - Stimulus: assert rst between edges with out_valid=1.
  - Required: out_valid=0, imem_addr=RESET_PC, counters=0 immediately, before the next edge.
